// File: rtl/sd_link_pkg.sv
// Shared types for the SD-SPI link router.
package sd_link_pkg;

  // Safe-switch FSM states
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SWITCH
  } fsm_e;

  // Wide enough for one physical target plus up to seven virtual slots
  localparam int unsigned TGT_W = 3;
  typedef logic [TGT_W-1:0] tgt_t;

  // Target 0 is always the physical card
  localparam tgt_t TGT_PHY = '0;

endpackage

// File: rtl/sd_link_mux_act_timer.sv
// Per-target inactivity timer: restarts on kick, saturates at TIMEOUT.
module sd_act_timer #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic kick,
  output logic act
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  // Count idle cycles since the last kick, holding at the limit
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q <= LIMIT;
    end else if (kick) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign act = (cnt_q < LIMIT);

endmodule

// File: rtl/sd_link_mux.sv
// SD-SPI router between the core's SPI master, the physical card and the
// HPS-backed virtual slots. Target changes only commit on a settled idle bus.
module sd_link_mux
  import sd_link_pkg::*;
#(
  parameter int unsigned NUM_VIRT = 1,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned SEL_W    = $clog2(NUM_VIRT + 1)
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [NUM_VIRT-1:0] img_mounted,
  input  logic [NUM_VIRT-1:0] img_nz,
  input  logic                sck,
  input  logic                ss,
  input  logic                mosi,
  output logic                miso,
  output logic                phy_sck,
  output logic                phy_ss,
  output logic                phy_mosi,
  input  logic                phy_miso,
  output logic                v_sck,
  output logic                v_mosi,
  output logic [NUM_VIRT-1:0] v_ss,
  input  logic [NUM_VIRT-1:0] v_miso,
  output logic [SEL_W-1:0]    sel,
  output logic                busy,
  output logic [NUM_VIRT:0]   act,
  output logic                led_user,
  output logic                led_disk
);

  localparam int unsigned SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE - 1);

  fsm_e              state_q;
  tgt_t              sel_q;
  tgt_t              pending_q;
  logic [SCNT_W-1:0] scnt_q;

  logic req_valid;
  tgt_t req;
  tgt_t next_pend;

  // Mount arbiter: descending scan so the lowest valid slot wins
  always_comb begin
    req_valid = 1'b0;
    req       = TGT_PHY;
    for (int k = int'(NUM_VIRT) - 1; k >= 0; k--) begin
      if (img_mounted[k]) begin
        if (img_nz[k]) begin
          req_valid = 1'b1;
          req       = tgt_t'(k + 1);
        end else if (sel_q == tgt_t'(k + 1) ||
                     (state_q != IDLE && pending_q == tgt_t'(k + 1))) begin
          // Ejecting the live or pending slot falls back to the physical card
          req_valid = 1'b1;
          req       = TGT_PHY;
        end
      end
    end
  end

  assign next_pend = req_valid ? req : pending_q;

  // Safe-switch FSM: wait for SETTLE consecutive deselected cycles, then commit
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= TGT_PHY;
      pending_q <= TGT_PHY;
      scnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req != sel_q) begin
            state_q   <= WAIT;
            pending_q <= req;
            scnt_q    <= '0;
          end
        end
        WAIT: begin
          pending_q <= next_pend;
          if (next_pend == sel_q) begin
            state_q <= IDLE;
          end else if (ss) begin
            if (scnt_q == SETTLE_LAST) begin
              state_q <= SWITCH;
            end else begin
              scnt_q <= scnt_q + 1'b1;
            end
          end else begin
            scnt_q <= '0;
          end
        end
        SWITCH: begin
          sel_q   <= pending_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Routing: only the committed target sees the bus; all parked during the switch
  always_comb begin
    phy_sck  = 1'b0;
    phy_ss   = 1'b1;
    phy_mosi = 1'b0;
    v_sck    = 1'b0;
    v_mosi   = 1'b0;
    v_ss     = '1;
    miso     = 1'b1;
    if (!reset && state_q != SWITCH) begin
      if (sel_q == TGT_PHY) begin
        phy_sck  = sck;
        phy_ss   = ss;
        phy_mosi = mosi;
        miso     = phy_miso;
      end else begin
        v_sck  = sck;
        v_mosi = mosi;
        for (int k = 0; k < int'(NUM_VIRT); k++) begin
          if (sel_q == tgt_t'(k + 1)) begin
            v_ss[k] = ss;
            miso    = v_miso[k];
          end
        end
      end
    end
  end

  logic [1:0] mosi_h;
  logic [1:0] miso_h;
  logic       toggle;

  // Two-stage data history; miso idles high on SPI
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mosi_h <= 2'b00;
      miso_h <= 2'b11;
    end else begin
      mosi_h <= {mosi_h[0], mosi};
      miso_h <= {miso_h[0], miso};
    end
  end

  assign toggle = (mosi_h[1] ^ mosi_h[0]) | (miso_h[1] ^ miso_h[0]);

  for (genvar t = 0; t < NUM_VIRT + 1; t++) begin : g_tgt
    sd_act_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clk_sys(clk_sys),
      .reset  (reset),
      .kick   (toggle && (sel_q == tgt_t'(t))),
      .act    (act[t])
    );
  end

  assign sel      = sel_q[SEL_W-1:0];
  assign busy     = (state_q != IDLE);
  assign led_user = |act[NUM_VIRT:1];
  assign led_disk = act[0];

endmodule

// File: tb/tb_sd_link_mux.sv
// Bench for sd_link_mux: directed scenarios followed by random traffic, all
// checked against a cycle-level behavioural model.
module tb_sd_link_mux;

  localparam int NV = 2;
  localparam int TO = 100;
  localparam int ST = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [NV-1:0] img_mounted, img_nz;
  logic          sck, ss, mosi, miso;
  logic          phy_sck, phy_ss, phy_mosi, phy_miso;
  logic          v_sck, v_mosi;
  logic [NV-1:0] v_ss, v_miso;
  logic [1:0]    sel;
  logic          busy;
  logic [NV:0]   act;
  logic          led_user, led_disk;

  int checks = 0;
  int failures = 0;

  // Model state: phase 0 idle, 1 waiting for a quiet bus, 2 committing
  int m_sel, m_pend, m_phase, m_run, edge_n;
  int last_kick[NV+1];
  bit seen[NV+1];
  bit pm1, pm2, qm1, qm2;

  sd_link_mux #(
    .NUM_VIRT(NV),
    .TIMEOUT (TO),
    .SETTLE  (ST)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .img_mounted(img_mounted),
    .img_nz     (img_nz),
    .sck        (sck),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso),
    .phy_sck    (phy_sck),
    .phy_ss     (phy_ss),
    .phy_mosi   (phy_mosi),
    .phy_miso   (phy_miso),
    .v_sck      (v_sck),
    .v_mosi     (v_mosi),
    .v_ss       (v_ss),
    .v_miso     (v_miso),
    .sel        (sel),
    .busy       (busy),
    .act        (act),
    .led_user   (led_user),
    .led_disk   (led_disk)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit exp_miso();
    if (reset || m_phase == 2) return 1'b1;
    if (m_sel == 0) return phy_miso;
    return v_miso[m_sel-1];
  endfunction

  task automatic model_reset();
    m_sel = 0; m_pend = 0; m_phase = 0; m_run = 0; edge_n = 0;
    for (int t = 0; t <= NV; t++) begin
      seen[t] = 1'b0;
      last_kick[t] = 0;
    end
    pm1 = 1'b0; pm2 = 1'b0; qm1 = 1'b1; qm2 = 1'b1;
  endtask

  task automatic model_edge();
    bit rv;
    int r;
    bit cur_miso;
    edge_n++;
    // A data change seen two samples back refreshes the current target
    if (pm1 != pm2 || qm1 != qm2) begin
      last_kick[m_sel] = edge_n;
      seen[m_sel] = 1'b1;
    end
    cur_miso = exp_miso();
    pm2 = pm1; pm1 = mosi;
    qm2 = qm1; qm1 = cur_miso;
    rv = 1'b0; r = 0;
    for (int k = NV - 1; k >= 0; k--) begin
      if (img_mounted[k]) begin
        if (img_nz[k]) begin
          rv = 1'b1; r = k + 1;
        end else if (m_sel == k + 1 || (m_phase != 0 && m_pend == k + 1)) begin
          rv = 1'b1; r = 0;
        end
      end
    end
    case (m_phase)
      0: if (rv && r != m_sel) begin
        m_phase = 1; m_pend = r; m_run = 0;
      end
      1: begin
        if (rv) m_pend = r;
        if (m_pend == m_sel) m_phase = 0;
        else if (ss) begin
          m_run++;
          if (m_run == ST) m_phase = 2;
        end else m_run = 0;
      end
      default: begin
        m_sel = m_pend;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic check_all(input string ph);
    logic          e_pss, e_psck, e_pmosi, e_vsck, e_vmosi, e_miso;
    logic [NV-1:0] e_vss;
    logic [NV:0]   e_act;
    e_pss = 1'b1; e_psck = 1'b0; e_pmosi = 1'b0;
    e_vsck = 1'b0; e_vmosi = 1'b0; e_vss = '1;
    e_miso = exp_miso();
    if (!reset && m_phase != 2) begin
      if (m_sel == 0) begin
        e_pss = ss; e_psck = sck; e_pmosi = mosi;
      end else begin
        e_vsck = sck; e_vmosi = mosi; e_vss[m_sel-1] = ss;
      end
    end
    for (int t = 0; t <= NV; t++) e_act[t] = seen[t] && (edge_n - last_kick[t] < TO);
    check($sformatf("%s.sel", ph), 32'(sel), 32'(m_sel));
    check($sformatf("%s.busy", ph), 32'(busy), 32'(m_phase != 0));
    check($sformatf("%s.act", ph), 32'(act), 32'(e_act));
    check($sformatf("%s.led_user", ph), 32'(led_user), 32'(|e_act[NV:1]));
    check($sformatf("%s.led_disk", ph), 32'(led_disk), 32'(e_act[0]));
    check($sformatf("%s.miso", ph), 32'(miso), 32'(e_miso));
    check($sformatf("%s.phy_ss", ph), 32'(phy_ss), 32'(e_pss));
    check($sformatf("%s.phy_sck", ph), 32'(phy_sck), 32'(e_psck));
    check($sformatf("%s.phy_mosi", ph), 32'(phy_mosi), 32'(e_pmosi));
    check($sformatf("%s.v_ss", ph), 32'(v_ss), 32'(e_vss));
    check($sformatf("%s.v_sck", ph), 32'(v_sck), 32'(e_vsck));
    check($sformatf("%s.v_mosi", ph), 32'(v_mosi), 32'(e_vmosi));
  endtask

  task automatic tick(input string ph);
    @(posedge clk_sys);
    if (!reset) model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic mount(input int k, input bit nz, input string ph);
    img_mounted[k] = 1'b1;
    img_nz[k] = nz;
    tick(ph);
    img_mounted = '0;
    img_nz = '0;
  endtask

  initial begin
    reset = 1'b1;
    img_mounted = '0; img_nz = '0;
    sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    phy_miso = 1'b1; v_miso = '1;
    model_reset();
    #1;
    // 1: reset state
    check_all("t1");
    check("t1.sel0", 32'(sel), 32'd0);
    check("t1.vss11", 32'(v_ss), 32'h3);
    check("t1.act0", 32'(act), 32'd0);
    check("t1.miso1", 32'(miso), 32'd1);
    tick("t1r");
    tick("t1r");
    @(negedge clk_sys);
    reset = 1'b0;

    // 2: switch to slot 1 on an idle bus
    mount(1, 1'b1, "t2m");
    check("t2.busy", 32'(busy), 32'd1);
    repeat (ST) tick("t2w");
    check("t2.sel_hold", 32'(sel), 32'd0);
    tick("t2s");
    check("t2.sel", 32'(sel), 32'd2);
    ss = 1'b0;
    #1;
    check("t2.vss", 32'(v_ss), 32'h1);
    check_all("t2x");

    // 3: active bus blocks the switch until ss rises
    mount(0, 1'b1, "t3m");
    repeat (30) tick("t3h");
    check("t3.sel_hold", 32'(sel), 32'd2);
    check("t3.busy", 32'(busy), 32'd1);
    ss = 1'b1;
    repeat (ST) tick("t3w");
    check("t3.sel_pre", 32'(sel), 32'd2);
    tick("t3s");
    check("t3.sel", 32'(sel), 32'd1);

    // eject the live slot -> back to physical
    mount(0, 1'b0, "t3u");
    repeat (ST + 1) tick("t3uw");
    check("t3.sel_phy", 32'(sel), 32'd0);

    // 4: retarget while waiting; settle count carries over
    mount(1, 1'b1, "t4m1");
    repeat (5) tick("t4w");
    mount(0, 1'b1, "t4m0");
    repeat (10) tick("t4w2");
    check("t4.sel_pre", 32'(sel), 32'd0);
    tick("t4s");
    check("t4.sel", 32'(sel), 32'd1);
    mount(0, 1'b0, "t4u");
    repeat (ST + 1) tick("t4uw");
    check("t4.sel_phy", 32'(sel), 32'd0);

    // 5: activity LED on slot 0 then timeout
    mount(0, 1'b1, "t5m");
    repeat (ST + 1) tick("t5w");
    check("t5.sel", 32'(sel), 32'd1);
    for (int i = 0; i < 10; i++) begin
      mosi = ~mosi;
      tick("t5t");
    end
    check("t5.act1", 32'(act[1]), 32'd1);
    check("t5.led_user", 32'(led_user), 32'd1);
    repeat (TO + 10) tick("t5i");
    check("t5.act_off", 32'(act), 32'd0);
    check("t5.led_off", 32'(led_user), 32'd0);

    // 6: reset during WAIT
    mount(1, 1'b1, "t6m");
    repeat (5) tick("t6w");
    reset = 1'b1;
    #1;
    check("t6.sel", 32'(sel), 32'd0);
    check("t6.busy", 32'(busy), 32'd0);
    model_reset();
    check_all("t6r");
    tick("t6h");
    tick("t6h");
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (ST + 9) tick("t6p");
    check("t6.sel_after", 32'(sel), 32'd0);
    check("t6.busy_after", 32'(busy), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      ss = ($urandom_range(0, 7) != 0);
      sck = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) mosi = ~mosi;
      if ($urandom_range(0, 3) == 0) phy_miso = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) v_miso = NV'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0)
        mount(int'($urandom_range(0, NV - 1)), 1'($urandom_range(0, 3) != 0), "rnd");
      else
        tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
